ula_seq_ctrl: RTL and testbench

- Multi-byte sequencer for the 8-bit 74181-based ALU (ula_8_bits).
- Accepts an NBYTES-wide operation, then drives the ALU one byte per cycle, LSB first.
- Chains ALU carry-out into the next byte's carry-in, assembles the full result and reports carry and equality.
- Sits between a requester (e.g. CPU datapath) and a single shared ula_8_bits instance, which the parent instantiates.

---
 rtl/ula_pkg.sv | 29 ++
 rtl/ula_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_ula_seq_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ula_pkg
// Description : Shared types and constants for the multi-byte 74181 sequencer.
//               Provides the controller state encoding, the common 74181
//               function-select codes, and the carry-in codes. The 74181 uses
//               an active-low carry convention.
// Revision    : 1.0 - initial release
// ============================================================================
package ula_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Function-select codes for the 74181.
    // SUB uses m=0. XOR uses the same code with m=1.
    localparam logic [3:0] ULA_S_ADD = 4'b1001;
    localparam logic [3:0] ULA_S_SUB = 4'b0110;
    localparam logic [3:0] ULA_S_XOR = 4'b0110;

    // Carry-in codes. The carry is active-low.
    localparam logic ULA_CIN_NONE = 1'b1;
    localparam logic ULA_CIN_ONE  = 1'b0;

endpackage : ula_pkg
`default_nettype wire

// File: rtl/ula_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ula_seq_ctrl
// Description : Multi-byte sequencer for a shared 8-bit 74181 ALU. The block
//               latches an NBYTES-wide operation. It then drives the ALU one
//               byte per cycle, starting with the least significant byte. The
//               ALU carry-out of each byte feeds the carry-in of the next
//               byte. The block assembles the full result and reports the
//               final carry and the byte-wise equality.
// Revision    : 1.0 - initial release
//
// Parameters  : NBYTES      number of operand bytes (1..16)
// Macro       : ULA_SEQ_ABORT_EN  adds an 'abort' input. Asserting abort
//               during RUN returns the block to IDLE without a done pulse.
//
// Ports       : clk, rst              clock, synchronous active-high reset
//               start / ready         request handshake (accept = start&&ready)
//               op_a, op_b            operands, sampled on accept
//               op_s, op_m, op_c_in   ALU select, mode, initial carry (act-low)
//               done                  one-cycle pulse, results valid
//               result, c_out, eq     assembled result, top carry, equality
//               alu_a..alu_c_in       byte-wise drive to the ALU
//               alu_f, alu_c_out,
//               alu_a_eq_b            ALU responses (combinational)
// ============================================================================
module ula_seq_ctrl
    import ula_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
`ifdef ULA_SEQ_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  ready,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    input  logic [3:0]            op_s,
    input  logic                  op_m,
    input  logic                  op_c_in,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  c_out,
    output logic                  eq,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [3:0]            alu_s,
    output logic                  alu_m,
    output logic                  alu_c_in,
    input  logic [7:0]            alu_f,
    input  logic                  alu_c_out,
    input  logic                  alu_a_eq_b
);

    localparam int              IDXW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int              W        = 8 * NBYTES;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [3:0]      r_s;
    logic            r_m;
    logic            r_carry;
    logic            r_eq_acc;
    logic [IDXW-1:0] r_idx;

    // The bit offset of the current byte.
    logic [IDXW+2:0] w_off;
    assign w_off = {r_idx, 3'b000};

    assign ready    = (r_state == IDLE) || (r_state == DONE);
    assign alu_a    = (r_state == RUN) ? r_a[w_off +: 8] : 8'h00;
    assign alu_b    = (r_state == RUN) ? r_b[w_off +: 8] : 8'h00;
    assign alu_s    = r_s;
    assign alu_m    = r_m;
    assign alu_c_in = r_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_s      <= 4'h0;
            r_m      <= 1'b0;
            r_carry  <= ULA_CIN_NONE;
            r_eq_acc <= 1'b0;
            r_idx    <= '0;
            result   <= '0;
            c_out    <= 1'b1;
            eq       <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a      <= op_a;
                        r_b      <= op_b;
                        r_s      <= op_s;
                        r_m      <= op_m;
                        r_carry  <= op_c_in;
                        r_eq_acc <= 1'b1;
                        r_idx    <= '0;
                        r_state  <= RUN;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                RUN: begin
`ifdef ULA_SEQ_ABORT_EN
                    // An abort drops the current byte. The c_out and eq
                    // outputs keep their values from the previous operation.
                    if (abort) begin
                        r_state <= IDLE;
                        r_idx   <= '0;
                    end else
`endif
                    begin
                        result[w_off +: 8] <= alu_f;
                        r_carry            <= alu_c_out;
                        r_eq_acc           <= r_eq_acc & alu_a_eq_b;
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= DONE;
                            done    <= 1'b1;
                            c_out   <= alu_c_out;
                            eq      <= r_eq_acc & alu_a_eq_b;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : ula_seq_ctrl
`default_nettype wire

// File: tb/tb_ula_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ula_seq_ctrl
// Description : Self-checking bench for ula_seq_ctrl. It uses one instance
//               with NBYTES=4 and one with NBYTES=1. Each instance is paired
//               with a behavioural 8-bit 74181 model. Expected results come
//               from a full-width 74181 reference and go into a queue per
//               instance when an operation is accepted. Each done pulse pops
//               one entry from the queue and compares it with the outputs.
//               The ULA_SEQ_ABORT_EN macro enables the abort scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_seq_ctrl;
    import ula_pkg::*;

    typedef struct {
        logic [127:0] res;
        logic         cout;
        logic         eq;
        logic         chk_cout;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q4[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT with NBYTES = 4 ----------------
    logic        start4 = 1'b0, abort4 = 1'b0, ready4, done4, cout4, eq4;
    logic [31:0] a4 = '0, b4 = '0, result4;
    logic [3:0]  s4 = '0, alu_s4;
    logic        m4 = 1'b0, cin4 = 1'b1;
    logic [7:0]  alu_a4, alu_b4, alu_f4;
    logic        alu_m4, alu_cin4, alu_cout4, alu_eq4;

    ula_seq_ctrl #(.NBYTES(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
`ifdef ULA_SEQ_ABORT_EN
        .abort      (abort4),
`endif
        .ready      (ready4),
        .op_a       (a4),
        .op_b       (b4),
        .op_s       (s4),
        .op_m       (m4),
        .op_c_in    (cin4),
        .done       (done4),
        .result     (result4),
        .c_out      (cout4),
        .eq         (eq4),
        .alu_a      (alu_a4),
        .alu_b      (alu_b4),
        .alu_s      (alu_s4),
        .alu_m      (alu_m4),
        .alu_c_in   (alu_cin4),
        .alu_f      (alu_f4),
        .alu_c_out  (alu_cout4),
        .alu_a_eq_b (alu_eq4)
    );

    // ---------------- DUT with NBYTES = 1 ----------------
    logic        start1 = 1'b0, ready1, done1, cout1, eq1;
    logic [7:0]  a1 = '0, b1 = '0, result1;
    logic [3:0]  s1 = '0, alu_s1;
    logic        m1 = 1'b0, cin1 = 1'b1;
    logic [7:0]  alu_a1, alu_b1, alu_f1;
    logic        alu_m1, alu_cin1, alu_cout1, alu_eq1;

    ula_seq_ctrl #(.NBYTES(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
`ifdef ULA_SEQ_ABORT_EN
        .abort      (1'b0),
`endif
        .ready      (ready1),
        .op_a       (a1),
        .op_b       (b1),
        .op_s       (s1),
        .op_m       (m1),
        .op_c_in    (cin1),
        .done       (done1),
        .result     (result1),
        .c_out      (cout1),
        .eq         (eq1),
        .alu_a      (alu_a1),
        .alu_b      (alu_b1),
        .alu_s      (alu_s1),
        .alu_m      (alu_m1),
        .alu_c_in   (alu_cin1),
        .alu_f      (alu_f1),
        .alu_c_out  (alu_cout1),
        .alu_a_eq_b (alu_eq1)
    );

    // Behavioural 8-bit 74181 with active-high data and an active-low carry.
    function automatic logic [8:0] alu181(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] s, input logic m,
                                          input logic cin);
        logic [7:0] x, y;
        logic [8:0] sum;
        x = a | (b & {8{s[0]}}) | (~b & {8{s[1]}});
        y = (a & ~b & {8{s[2]}}) | (a & b & {8{s[3]}});
        if (m) return {1'b1, ~(x ^ y)};
        sum = {1'b0, x} + {1'b0, y} + {8'b0, ~cin};
        return {~sum[8], sum[7:0]};
    endfunction

    always_comb begin
        {alu_cout4, alu_f4} = alu181(alu_a4, alu_b4, alu_s4, alu_m4, alu_cin4);
        alu_eq4             = (alu_a4 == alu_b4);
        {alu_cout1, alu_f1} = alu181(alu_a1, alu_b1, alu_s1, alu_m1, alu_cin1);
        alu_eq1             = (alu_a1 == alu_b1);
    end

    // Full-width 74181 reference. It treats the whole operand as one
    // wide ALU, with no byte boundaries.
    function automatic exp_t ref_op(input logic [127:0] a, input logic [127:0] b,
                                    input logic [3:0] s, input logic m,
                                    input logic cin, input int nb, input logic chk);
        exp_t         e;
        logic [127:0] mask, x, y;
        logic [128:0] sum;
        mask = (nb == 16) ? {128{1'b1}} : ((128'h1 << (8 * nb)) - 128'h1);
        x    = (a | (b & {128{s[0]}}) | (~b & {128{s[1]}})) & mask;
        y    = ((a & ~b & {128{s[2]}}) | (a & b & {128{s[3]}})) & mask;
        sum  = {1'b0, x} + {1'b0, y} + {128'b0, ~cin};
        e.res      = m ? (~(x ^ y) & mask) : (sum[127:0] & mask);
        e.cout     = ~sum[8 * nb];
        e.eq       = ((a & mask) == (b & mask));
        e.chk_cout = chk & ~m;
        e.acc      = 0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Scoreboard monitors. Each done pulse pops the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done4) begin
            if (q4.size() == 0) begin
                check("unexpected_done4", 1, 0);
            end else begin
                e = q4.pop_front();
                check("result4", result4, e.res);
                if (e.chk_cout) check("c_out4", cout4, e.cout);
                check("eq4", eq4, e.eq);
                check("latency4", cyc - e.acc, 5);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                check("unexpected_done1", 1, 0);
            end else begin
                e = q1.pop_front();
                check("result1", result1, e.res);
                check("c_out1", cout1, e.cout);
                check("eq1", eq1, e.eq);
                check("latency1", cyc - e.acc, 2);
            end
        end
    end

    task automatic wait_ready4();
        int n = 0;
        while (!ready4 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready4) check("ready4_timeout", 0, 1);
    endtask

    // Drives one accepted request into dut4. On return, the bench is 1 time
    // unit past the accept edge.
    task automatic run4(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                        input logic m, input logic cin);
        exp_t e;
        wait_ready4();
        a4 = a; b4 = b; s4 = s; m4 = m; cin4 = cin; start4 = 1'b1;
        e = ref_op({96'b0, a}, {96'b0, b}, s, m, cin, 4, 1'b1);
        e.acc = cyc;
        q4.push_back(e);
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((q4.size() != 0 || q1.size() != 0) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_q4", q4.size(), 0);
        check("drain_q1", q1.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready4", ready4, 1);
        check("rst_result4", result4, 0);
        check("rst_c_out4", cout4, 1);
        check("rst_eq4", eq4, 0);
        check("rst_done4", done4, 0);
        check("rst_alu_a4", alu_a4, 0);
        check("rst_ready1", ready1, 1);
        @(posedge clk); #1;

        // Carry ripples through all four bytes.
        run4(32'hFFFF_FFFF, 32'h0000_0001, ULA_S_ADD, 1'b0, ULA_CIN_NONE);
        check("run_ready4", ready4, 0);
        drain(20);
        check("t1_result", result4, 32'h0);
        check("t1_c_out", cout4, 0);
        check("t1_eq", eq4, 0);

        // Subtract equal operands.
        run4(32'h1234_5678, 32'h1234_5678, ULA_S_SUB, 1'b0, ULA_CIN_ONE);
        drain(20);
        check("t2_result", result4, 32'h0);
        check("t2_c_out", cout4, 0);
        check("t2_eq", eq4, 1);

        // Logic XOR. A new request is held on start through RUN with
        // different operands. It must be ignored until the DONE cycle,
        // where it is accepted back-to-back.
        run4(32'hA5A5_A5A5, 32'hFFFF_0000, ULA_S_XOR, 1'b1, ULA_CIN_NONE);
        a4 = 32'h8000_0000; b4 = 32'h8000_0000; s4 = ULA_S_ADD; m4 = 1'b0;
        cin4 = ULA_CIN_NONE; start4 = 1'b1;
        n = 0;
        while (!done4 && n < 10) begin
            check("t3_ready_run", ready4, 0);
            @(posedge clk); #1;
            n++;
        end
        if (!done4) check("t3_done_timeout", 0, 1);
        check("t3_result", result4, 32'h5A5A_A5A5);
        check("t3_ready_done", ready4, 1);
        e = ref_op(128'h8000_0000, 128'h8000_0000, ULA_S_ADD, 1'b0, ULA_CIN_NONE, 4, 1'b1);
        e.acc = cyc;
        q4.push_back(e);
        @(posedge clk); #1;
        start4 = 1'b0;
        drain(20);
        check("t3b_c_out", cout4, 0);
        check("t3b_eq", eq4, 1);

        // Reset in the second RUN cycle, after byte 0 has been written.
        wait_ready4();
        a4 = 32'h0000_0011; b4 = 32'h0000_0022; s4 = ULA_S_ADD; m4 = 1'b0;
        cin4 = ULA_CIN_NONE; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", ready4, 1);
        check("mid_rst_result", result4, 0);
        check("mid_rst_c_out", cout4, 1);
        check("mid_rst_eq", eq4, 0);
        check("mid_rst_done", done4, 0);
        repeat (8) begin
            @(negedge clk);
            check("mid_rst_no_done", done4, 0);
        end
        @(posedge clk); #1;

        // Single-byte instance.
        a1 = 8'h7F; b1 = 8'h01; s1 = ULA_S_ADD; m1 = 1'b0; cin1 = ULA_CIN_NONE; start1 = 1'b1;
        e = ref_op(128'h7F, 128'h01, ULA_S_ADD, 1'b0, ULA_CIN_NONE, 1, 1'b1);
        e.acc = cyc;
        q1.push_back(e);
        @(posedge clk); #1;
        start1 = 1'b0;
        drain(10);
        check("t5_result", result1, 8'h80);
        check("t5_c_out", cout1, 1);

`ifdef ULA_SEQ_ABORT_EN
        // Set c_out=0 and eq=1. The aborted op must leave both unchanged.
        run4(32'h1234_5678, 32'h1234_5678, ULA_S_SUB, 1'b0, ULA_CIN_ONE);
        drain(20);
        wait_ready4();
        a4 = 32'h0101_0101; b4 = 32'h0202_0202; s4 = ULA_S_ADD; m4 = 1'b0;
        cin4 = ULA_CIN_NONE; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort4 = 1'b1;
        @(posedge clk); #1;
        abort4 = 1'b0;
        check("abort_ready", ready4, 1);
        check("abort_done", done4, 0);
        check("abort_c_out", cout4, 0);
        check("abort_eq", eq4, 1);
        check("abort_low_bytes", result4[15:0], 16'h0303);
        check("abort_top_byte", result4[31:24], 8'h00);
        repeat (6) begin
            @(negedge clk);
            check("abort_no_done", done4, 0);
        end
        @(posedge clk); #1;
        run4(32'h0000_00FF, 32'h0000_0001, ULA_S_ADD, 1'b0, ULA_CIN_NONE);
        drain(20);
        check("post_abort_result", result4, 32'h0000_0100);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ula_seq_ctrl
`default_nettype wire
